store_merge_buffer: RTL and testbench

Posted-store buffer between the store unit and store port of the non-blocking L1 data cache (`dcache_req_i_t`/`dcache_req_o_t` port 2). It accepts committed stores, merges stores to the same 64-bit doubleword into the youngest entry, and drains entries in FIFO order as single-doubleword cache writes. It also provides a page-offset match for load hazard checking and an empty indication for fence/flush sequencing.

---
 rtl/store_merge_buffer_pkg.sv | 56 +++++
 rtl/store_merge_buffer.sv | 156 +++++++++++++++
 tb/tb_store_merge_buffer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_merge_buffer_pkg.sv
// Shared types for the L1 store merge buffer: cache store-port structs,
// buffer entry layout, drain FSM encoding and a byte-lane merge helper.
package store_merge_buffer_pkg;

    localparam int unsigned PADDR_W   = 56;
    localparam int unsigned DW_ADDR_W = PADDR_W - 3;
    localparam int unsigned INDEX_W   = 12;
    localparam int unsigned TAG_W     = PADDR_W - INDEX_W;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned BE_W      = DATA_W / 8;

    typedef struct packed {
        logic [INDEX_W-1:0] address_index;
        logic [TAG_W-1:0]   address_tag;
        logic [DATA_W-1:0]  data_wdata;
        logic               data_req;
        logic               data_we;
        logic [BE_W-1:0]    data_be;
        logic [1:0]         data_size;
        logic               kill_req;
        logic               tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic              data_gnt;
        logic              data_rvalid;
        logic [DATA_W-1:0] data_rdata;
    } dcache_req_o_t;

    typedef struct packed {
        logic                 valid;
        logic [DW_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]    data;
        logic [BE_W-1:0]      be;
    } smb_entry_t;

    typedef enum logic [1:0] {
        SMB_IDLE = 2'd0,
        SMB_WAIT = 2'd1,
        SMB_REQ  = 2'd2
    } smb_state_e;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_data,
        input logic [DATA_W-1:0] new_data,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_data;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) res[8*b +: 8] = new_data[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/store_merge_buffer.sv
// Posted-store buffer: merges committed stores per doubleword into the
// youngest entry and drains the oldest entry as a single cache write.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   SMB_IDLE | buffer empty, nothing to drain
//   SMB_WAIT | entries held, age counter gives a lone entry time to merge
//   SMB_REQ  | head entry presented to the cache, held until data_gnt
module store_merge_buffer
    import store_merge_buffer_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned DRAIN_TIMEOUT = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          st_valid_i,
    output logic          st_ready_o,
    input  logic [55:0]   st_paddr_i,
    input  logic [63:0]   st_data_i,
    input  logic [7:0]    st_be_i,
    input  logic [11:0]   check_offset_i,
    output logic          match_o,
    output logic          empty_o,
    output dcache_req_i_t req_port_o,
    input  dcache_req_o_t req_port_i
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam logic [7:0]  AGE_LAST = 8'(DRAIN_TIMEOUT - 1);

    smb_entry_t           entries_q [DEPTH];
    logic [PTR_W-1:0]     head_q, tail_q, tail_m1, head_nxt;
    logic [CNT_W-1:0]     count_q, count_nxt;
    logic [7:0]           age_q, age_nxt;
    smb_state_e           state_q, state_nxt;
    logic [DW_ADDR_W-1:0] st_addr;
    logic                 locked, merge_hit, merge_into_head, push, pop, go_req;
    logic [7:0]           head_be_nxt;
    logic                 unused_inputs;

    assign unused_inputs = ^{req_port_i.data_rvalid, req_port_i.data_rdata, st_paddr_i[2:0]};

    assign st_addr   = st_paddr_i[55:3];
    assign tail_m1   = tail_q - PTR_W'(1);
    assign locked    = (tail_m1 == head_q) && (state_q == SMB_REQ);
    assign merge_hit = st_valid_i && !flush_i && (count_q != '0)
                       && (st_addr == entries_q[tail_m1].addr) && !locked;
    assign push      = st_valid_i && !merge_hit && (count_q < CNT_W'(DEPTH));
    assign pop       = (state_q == SMB_REQ) && req_port_i.data_gnt;

    assign st_ready_o = merge_hit || (count_q < CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);

    assign count_nxt       = count_q + CNT_W'(push) - CNT_W'(pop);
    assign head_nxt        = pop ? head_q + PTR_W'(1) : head_q;
    assign merge_into_head = merge_hit && (tail_m1 == head_nxt);

    // Drain decisions look at the post-edge head so that a full-mask store
    // or a completing merge requests in the very next cycle.
    always_comb begin
        head_be_nxt = entries_q[head_nxt].be;
        if (push && (tail_q == head_nxt)) begin
            head_be_nxt = st_be_i;
        end else if (merge_into_head) begin
            head_be_nxt = entries_q[head_nxt].be | st_be_i;
        end
    end

    always_comb begin
        age_nxt = age_q;
        if (push || merge_into_head || pop) begin
            age_nxt = '0;
        end else if (state_q == SMB_WAIT) begin
            age_nxt = age_q + 8'd1;
        end
    end

    assign go_req = (count_nxt >= CNT_W'(2)) || (head_be_nxt == 8'hFF)
                    || flush_i || (age_nxt == AGE_LAST);

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            SMB_IDLE: if (push) state_nxt = go_req ? SMB_REQ : SMB_WAIT;
            SMB_WAIT: if (go_req) state_nxt = SMB_REQ;
            SMB_REQ: begin
                if (pop) begin
                    if (count_nxt == '0) state_nxt = SMB_IDLE;
                    else                 state_nxt = go_req ? SMB_REQ : SMB_WAIT;
                end
            end
            default: state_nxt = SMB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SMB_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            age_q   <= '0;
        end else begin
            state_q <= state_nxt;
            head_q  <= head_nxt;
            count_q <= count_nxt;
            age_q   <= age_nxt;
            if (push) tail_q <= tail_q + PTR_W'(1);
        end
    end

    // Pop and push never hit the same slot: push needs a free slot, and the
    // head is never the merge target while it is being presented.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
        end else begin
            if (pop) entries_q[head_q].valid <= 1'b0;
            if (push) begin
                entries_q[tail_q] <= '{valid: 1'b1, addr: st_addr,
                                       data: st_data_i, be: st_be_i};
            end
            if (merge_hit) begin
                entries_q[tail_m1].data <= merge_bytes(entries_q[tail_m1].data,
                                                       st_data_i, st_be_i);
                entries_q[tail_m1].be   <= entries_q[tail_m1].be | st_be_i;
            end
        end
    end

    always_comb begin
        match_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].valid && (entries_q[i].addr[8:0] == check_offset_i[11:3])) begin
                match_o = 1'b1;
            end
        end
    end

    always_comb begin
        req_port_o = '0;
        if (state_q == SMB_REQ) begin
            req_port_o.address_index = {entries_q[head_q].addr[8:0], 3'b000};
            req_port_o.address_tag   = entries_q[head_q].addr[52:9];
            req_port_o.data_wdata    = entries_q[head_q].data;
            req_port_o.data_be       = entries_q[head_q].be;
            req_port_o.data_req      = 1'b1;
            req_port_o.data_we       = 1'b1;
            req_port_o.data_size     = 2'b11;
        end
    end

endmodule

// File: tb/tb_store_merge_buffer.sv
// Directed bench for store_merge_buffer: timeout drain, merging, full buffer,
// head lock, load-offset match, flush drain and asynchronous reset.
module tb_store_merge_buffer;
    import store_merge_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DT    = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          st_valid_i;
    logic          st_ready_o;
    logic [55:0]   st_paddr_i;
    logic [63:0]   st_data_i;
    logic [7:0]    st_be_i;
    logic [11:0]   check_offset_i;
    logic          match_o;
    logic          empty_o;
    dcache_req_i_t req_port_o;
    dcache_req_o_t req_port_i;

    int tests_run    = 0;
    int tests_failed = 0;

    store_merge_buffer #(.DEPTH(DEPTH), .DRAIN_TIMEOUT(DT)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .st_valid_i     (st_valid_i),
        .st_ready_o     (st_ready_o),
        .st_paddr_i     (st_paddr_i),
        .st_data_i      (st_data_i),
        .st_be_i        (st_be_i),
        .check_offset_i (check_offset_i),
        .match_o        (match_o),
        .empty_o        (empty_o),
        .req_port_o     (req_port_o),
        .req_port_i     (req_port_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_store(input logic [55:0] a, input logic [63:0] d, input logic [7:0] be);
        st_valid_i = 1'b1;
        st_paddr_i = a;
        st_data_i  = d;
        st_be_i    = be;
    endtask

    task automatic wait_req(output int waited);
        waited = 0;
        while (!req_port_o.data_req && waited < 40) begin
            step();
            waited++;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; flush_i = 1'b0; st_valid_i = 1'b0; st_paddr_i = '0;
        st_data_i = '0; st_be_i = '0; check_offset_i = '0; req_port_i = '0;
        step(); step();
        rst_ni = 1'b1;
        step();
        tests_run++;
        if (st_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", st_ready_o); end
        tests_run++;
        if (empty_o !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b expected 1", empty_o); end
        tests_run++;
        if (match_o !== 1'b0) begin tests_failed++; $display("FAIL reset_match: got %b expected 0", match_o); end
        tests_run++;
        if (req_port_o !== '0) begin tests_failed++; $display("FAIL reset_req_port: got %h expected 0", req_port_o); end
    endtask

    task automatic test_timeout_drain();
        int waited;
        drive_store(56'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'h0F);
        #1;
        tests_run++;
        if (st_ready_o !== 1'b1) begin tests_failed++; $display("FAIL lone_ready: got %b expected 1", st_ready_o); end
        step();
        st_valid_i = 1'b0;
        tests_run++;
        if (empty_o !== 1'b0) begin tests_failed++; $display("FAIL lone_not_empty: got %b expected 0", empty_o); end
        wait_req(waited);
        waited++;
        tests_run++;
        if (waited != DT) begin tests_failed++; $display("FAIL lone_req_latency: got %0d expected %0d", waited, DT); end
        tests_run++;
        if (req_port_o.address_index !== 12'h010) begin tests_failed++; $display("FAIL lone_index: got %h expected 010", req_port_o.address_index); end
        tests_run++;
        if (req_port_o.address_tag !== 44'h80000) begin tests_failed++; $display("FAIL lone_tag: got %h expected 80000", req_port_o.address_tag); end
        tests_run++;
        if (req_port_o.data_be !== 8'h0F) begin tests_failed++; $display("FAIL lone_be: got %h expected 0f", req_port_o.data_be); end
        tests_run++;
        if ({req_port_o.data_we, req_port_o.data_size, req_port_o.kill_req, req_port_o.tag_valid} !== 5'b1_11_0_0) begin
            tests_failed++; $display("FAIL lone_ctrl: got we/size/kill/tv %b%b%b%b", req_port_o.data_we, req_port_o.data_size, req_port_o.kill_req, req_port_o.tag_valid);
        end
        req_port_i.data_gnt = 1'b1;
        step();
        req_port_i.data_gnt = 1'b0;
        tests_run++;
        if (empty_o !== 1'b1 || req_port_o.data_req !== 1'b0) begin
            tests_failed++; $display("FAIL lone_after_gnt: got empty %b req %b expected 1 0", empty_o, req_port_o.data_req);
        end
    endtask

    task automatic test_merge();
        drive_store(56'h8000_0020, 64'h1111_1111_AAAA_AAAA, 8'h0F);
        step();
        drive_store(56'h8000_0020, 64'hBBBB_BBBB_2222_2222, 8'hF0);
        #1;
        tests_run++;
        if (req_port_o.data_req !== 1'b0) begin tests_failed++; $display("FAIL merge_early_req: got %b expected 0", req_port_o.data_req); end
        step();
        st_valid_i = 1'b0;
        tests_run++;
        if (req_port_o.data_req !== 1'b1) begin tests_failed++; $display("FAIL merge_req: got %b expected 1", req_port_o.data_req); end
        tests_run++;
        if (req_port_o.data_be !== 8'hFF) begin tests_failed++; $display("FAIL merge_be: got %h expected ff", req_port_o.data_be); end
        tests_run++;
        if (req_port_o.data_wdata !== 64'hBBBB_BBBB_AAAA_AAAA) begin
            tests_failed++; $display("FAIL merge_data: got %h expected bbbbbbbbaaaaaaaa", req_port_o.data_wdata);
        end
        req_port_i.data_gnt = 1'b1;
        step();
        req_port_i.data_gnt = 1'b0;
        tests_run++;
        if (empty_o !== 1'b1) begin tests_failed++; $display("FAIL merge_single_write: got empty %b expected 1", empty_o); end
    endtask

    task automatic test_full();
        int waited;
        logic [7:0] exp_be;
        for (int i = 0; i < DEPTH; i++) begin
            drive_store(56'h8000_0100 + 56'(8 * i), 64'(i + 1), 8'h01);
            step();
        end
        drive_store(56'h8000_0120, 64'h0, 8'h01);
        #1;
        tests_run++;
        if (st_ready_o !== 1'b0) begin tests_failed++; $display("FAIL full_ready: got %b expected 0", st_ready_o); end
        drive_store(56'h8000_0118, 64'h0000_0000_0000_5500, 8'h02);
        #1;
        tests_run++;
        if (st_ready_o !== 1'b1) begin tests_failed++; $display("FAIL full_tail_merge_ready: got %b expected 1", st_ready_o); end
        step();
        st_valid_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wait_req(waited);
            tests_run++;
            if (req_port_o.data_req !== 1'b1) begin
                tests_failed++; $display("FAIL full_drain_timeout: entry %0d got no data_req", i);
            end
            tests_run++;
            if (req_port_o.address_index !== 12'h100 + 12'(8 * i)) begin
                tests_failed++; $display("FAIL full_order: entry %0d got index %h expected %h", i, req_port_o.address_index, 12'h100 + 12'(8 * i));
            end
            exp_be = (i == DEPTH - 1) ? 8'h03 : 8'h01;
            tests_run++;
            if (req_port_o.data_be !== exp_be) begin
                tests_failed++; $display("FAIL full_be: entry %0d got %h expected %h", i, req_port_o.data_be, exp_be);
            end
            if (i == DEPTH - 1) begin
                tests_run++;
                if (req_port_o.data_wdata !== 64'h5504) begin
                    tests_failed++; $display("FAIL full_merge_data: got %h expected 5504", req_port_o.data_wdata);
                end
            end
            req_port_i.data_gnt = 1'b1;
            step();
            req_port_i.data_gnt = 1'b0;
        end
        tests_run++;
        if (empty_o !== 1'b1) begin tests_failed++; $display("FAIL full_empty: got %b expected 1", empty_o); end
    endtask

    task automatic test_head_lock();
        int waited;
        drive_store(56'h8000_0200, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
        step();
        tests_run++;
        if (req_port_o.data_req !== 1'b1) begin tests_failed++; $display("FAIL lock_req_n1: got %b expected 1", req_port_o.data_req); end
        drive_store(56'h8000_0200, 64'h77, 8'h01);
        #1;
        tests_run++;
        if (st_ready_o !== 1'b1) begin tests_failed++; $display("FAIL lock_ready: got %b expected 1", st_ready_o); end
        step();
        st_valid_i = 1'b0;
        tests_run++;
        if (req_port_o.data_wdata !== 64'hDEAD_BEEF_CAFE_F00D) begin
            tests_failed++; $display("FAIL lock_head_stable: got %h expected deadbeefcafef00d", req_port_o.data_wdata);
        end
        req_port_i.data_gnt = 1'b1;
        step();
        req_port_i.data_gnt = 1'b0;
        tests_run++;
        if (empty_o !== 1'b0) begin tests_failed++; $display("FAIL lock_second_entry: got empty %b expected 0", empty_o); end
        wait_req(waited);
        tests_run++;
        if (req_port_o.data_req !== 1'b1 || req_port_o.data_be !== 8'h01 || req_port_o.address_index !== 12'h200) begin
            tests_failed++; $display("FAIL lock_second_write: got req %b be %h index %h expected 1 01 200", req_port_o.data_req, req_port_o.data_be, req_port_o.address_index);
        end
        req_port_i.data_gnt = 1'b1;
        step();
        req_port_i.data_gnt = 1'b0;
    endtask

    task automatic test_match();
        int waited;
        drive_store(56'h8000_1018, 64'h1, 8'h01);
        check_offset_i = 12'h018;
        #1;
        tests_run++;
        if (match_o !== 1'b0) begin tests_failed++; $display("FAIL match_same_cycle: got %b expected 0", match_o); end
        step();
        st_valid_i = 1'b0;
        #1;
        tests_run++;
        if (match_o !== 1'b1) begin tests_failed++; $display("FAIL match_018: got %b expected 1", match_o); end
        check_offset_i = 12'h01C;
        #1;
        tests_run++;
        if (match_o !== 1'b1) begin tests_failed++; $display("FAIL match_01c: got %b expected 1", match_o); end
        check_offset_i = 12'h020;
        #1;
        tests_run++;
        if (match_o !== 1'b0) begin tests_failed++; $display("FAIL match_020: got %b expected 0", match_o); end
        wait_req(waited);
        tests_run++;
        if (req_port_o.address_tag !== 44'h80001 || req_port_o.address_index !== 12'h018) begin
            tests_failed++; $display("FAIL match_drain_addr: got tag %h index %h expected 80001 018", req_port_o.address_tag, req_port_o.address_index);
        end
        req_port_i.data_gnt = 1'b1;
        step();
        req_port_i.data_gnt = 1'b0;
        check_offset_i = 12'h000;
    endtask

    task automatic test_flush();
        drive_store(56'h8000_0300, 64'h1, 8'h01);
        step();
        drive_store(56'h8000_0308, 64'h2, 8'h01);
        step();
        st_valid_i = 1'b0;
        tests_run++;
        if (req_port_o.data_req !== 1'b1 || req_port_o.address_index !== 12'h300) begin
            tests_failed++; $display("FAIL flush_first: got req %b index %h expected 1 300", req_port_o.data_req, req_port_o.address_index);
        end
        flush_i = 1'b1;
        req_port_i.data_gnt = 1'b1;
        step();
        tests_run++;
        if (req_port_o.data_req !== 1'b1 || req_port_o.address_index !== 12'h308) begin
            tests_failed++; $display("FAIL flush_back_to_back: got req %b index %h expected 1 308", req_port_o.data_req, req_port_o.address_index);
        end
        step();
        flush_i = 1'b0;
        req_port_i.data_gnt = 1'b0;
        tests_run++;
        if (empty_o !== 1'b1 || req_port_o.data_req !== 1'b0) begin
            tests_failed++; $display("FAIL flush_empty: got empty %b req %b expected 1 0", empty_o, req_port_o.data_req);
        end
    endtask

    task automatic test_reset_mid_req();
        drive_store(56'h8000_0400, 64'h55, 8'hFF);
        check_offset_i = 12'h400;
        step();
        st_valid_i = 1'b0;
        tests_run++;
        if (req_port_o.data_req !== 1'b1 || match_o !== 1'b1) begin
            tests_failed++; $display("FAIL rst_pre_state: got req %b match %b expected 1 1", req_port_o.data_req, match_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        tests_run++;
        if (req_port_o !== '0) begin tests_failed++; $display("FAIL rst_req_port: got %h expected 0", req_port_o); end
        tests_run++;
        if (empty_o !== 1'b1 || st_ready_o !== 1'b1 || match_o !== 1'b0) begin
            tests_failed++; $display("FAIL rst_outputs: got empty %b ready %b match %b expected 1 1 0", empty_o, st_ready_o, match_o);
        end
        step();
        rst_ni = 1'b1;
        step();
        tests_run++;
        if (empty_o !== 1'b1 || req_port_o.data_req !== 1'b0) begin
            tests_failed++; $display("FAIL rst_after_release: got empty %b req %b expected 1 0", empty_o, req_port_o.data_req);
        end
    endtask

    initial begin
        test_reset();
        test_timeout_drain();
        test_merge();
        test_full();
        test_head_lock();
        test_match();
        test_flush();
        test_reset_mid_req();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
